// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter onto one slave; grant takes 1 cycle, then AW/W/B pass through combinationally.
// Backpressure is the slave's ready and the granted master's bready; the loser sees no ready until re-arbitrated.
module axi_wr_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // master 0
   input  logic [3:0]  m0_awid_i,
   input  logic [31:0] m0_awaddr_i,
   input  logic [7:0]  m0_awlen_i,
   input  logic [2:0]  m0_awsize_i,
   input  logic [1:0]  m0_awburst_i,
   input  logic        m0_awvalid_i,
   output logic        m0_awready_o,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_wstrb_i,
   input  logic        m0_wlast_i,
   input  logic        m0_wvalid_i,
   output logic        m0_wready_o,
   output logic [3:0]  m0_bid_o,
   output logic [1:0]  m0_bresp_o,
   output logic        m0_bvalid_o,
   input  logic        m0_bready_i,
   // master 1
   input  logic [3:0]  m1_awid_i,
   input  logic [31:0] m1_awaddr_i,
   input  logic [7:0]  m1_awlen_i,
   input  logic [2:0]  m1_awsize_i,
   input  logic [1:0]  m1_awburst_i,
   input  logic        m1_awvalid_i,
   output logic        m1_awready_o,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_wstrb_i,
   input  logic        m1_wlast_i,
   input  logic        m1_wvalid_i,
   output logic        m1_wready_o,
   output logic [3:0]  m1_bid_o,
   output logic [1:0]  m1_bresp_o,
   output logic        m1_bvalid_o,
   input  logic        m1_bready_i,
   // shared slave
   output logic [3:0]  s_awid_o,
   output logic [31:0] s_awaddr_o,
   output logic [7:0]  s_awlen_o,
   output logic [2:0]  s_awsize_o,
   output logic [1:0]  s_awburst_o,
   output logic        s_awvalid_o,
   input  logic        s_awready_i,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_wstrb_o,
   output logic        s_wlast_o,
   output logic        s_wvalid_o,
   input  logic        s_wready_i,
   input  logic [3:0]  s_bid_i,
   input  logic [1:0]  s_bresp_i,
   input  logic        s_bvalid_i,
   output logic        s_bready_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t state;
   logic   gnt;
   logic   prio;
   logic   aw_done;
   logic   w_done;

   logic   busy;
   logic   resp;
   logic   g_awvalid;
   logic   g_wvalid;
   logic   g_wlast;
   logic   g_bready;
   logic   aw_hs;
   logic   w_hs;
   logic   wl_hs;
   logic   b_hs;
   logic   nxt_gnt;

   // Reset gates the phase decodes so every output drops in the cycle rst_i is high.
   assign busy = (state == BUSY) && !rst_i;
   assign resp = (state == RESP) && !rst_i;

   assign g_awvalid = gnt ? m1_awvalid_i : m0_awvalid_i;
   assign g_wvalid  = gnt ? m1_wvalid_i  : m0_wvalid_i;
   assign g_wlast   = gnt ? m1_wlast_i   : m0_wlast_i;
   assign g_bready  = gnt ? m1_bready_i  : m0_bready_i;

   assign aw_hs = busy && g_awvalid && s_awready_i && !aw_done;
   assign w_hs  = busy && g_wvalid && s_wready_i && !w_done;
   assign wl_hs = w_hs && g_wlast;
   assign b_hs  = resp && s_bvalid_i && g_bready;

   always_comb begin
      nxt_gnt = 1'b0;
      if (m0_awvalid_i && m1_awvalid_i)
         nxt_gnt = FIXED_PRIO ? 1'b0 : prio;
      else if (m1_awvalid_i)
         nxt_gnt = 1'b1;
   end

   always_comb begin
      s_awid_o    = '0;
      s_awaddr_o  = '0;
      s_awlen_o   = '0;
      s_awsize_o  = '0;
      s_awburst_o = '0;
      s_awvalid_o = 1'b0;
      s_wdata_o   = '0;
      s_wstrb_o   = '0;
      s_wlast_o   = 1'b0;
      s_wvalid_o  = 1'b0;
      if (busy) begin
         s_awid_o    = gnt ? m1_awid_i    : m0_awid_i;
         s_awaddr_o  = gnt ? m1_awaddr_i  : m0_awaddr_i;
         s_awlen_o   = gnt ? m1_awlen_i   : m0_awlen_i;
         s_awsize_o  = gnt ? m1_awsize_i  : m0_awsize_i;
         s_awburst_o = gnt ? m1_awburst_i : m0_awburst_i;
         s_awvalid_o = g_awvalid && !aw_done;
         s_wdata_o   = gnt ? m1_wdata_i   : m0_wdata_i;
         s_wstrb_o   = gnt ? m1_wstrb_i   : m0_wstrb_i;
         s_wlast_o   = g_wlast;
         s_wvalid_o  = g_wvalid && !w_done;
      end
   end

   always_comb begin
      m0_awready_o = busy && !gnt && s_awready_i && !aw_done;
      m1_awready_o = busy &&  gnt && s_awready_i && !aw_done;
      m0_wready_o  = busy && !gnt && s_wready_i && !w_done;
      m1_wready_o  = busy &&  gnt && s_wready_i && !w_done;
      m0_bvalid_o  = resp && !gnt && s_bvalid_i;
      m1_bvalid_o  = resp &&  gnt && s_bvalid_i;
      m0_bid_o     = (resp && !gnt) ? s_bid_i   : 4'd0;
      m1_bid_o     = (resp &&  gnt) ? s_bid_i   : 4'd0;
      m0_bresp_o   = (resp && !gnt) ? s_bresp_i : 2'd0;
      m1_bresp_o   = (resp &&  gnt) ? s_bresp_i : 2'd0;
      s_bready_o   = resp && g_bready;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         prio    <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_awvalid_i || m1_awvalid_i) begin
                  gnt     <= nxt_gnt;
                  state   <= BUSY;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            BUSY: begin
               if (aw_hs)
                  aw_done <= 1'b1;
               if (wl_hs)
                  w_done <= 1'b1;
               // Beats without wlast leave the flags alone; only the last beat closes W.
               if ((aw_done || aw_hs) && (w_done || wl_hs))
                  state <= RESP;
            end
            RESP: begin
               if (b_hs) begin
                  state <= IDLE;
                  prio  <= ~gnt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized and directed bench: both FIXED_PRIO variants run on shared stimulus against a transaction model.
module tb_axi_wr_arbiter;

   typedef struct packed {
      logic        m0_awready;
      logic        m0_wready;
      logic [3:0]  m0_bid;
      logic [1:0]  m0_bresp;
      logic        m0_bvalid;
      logic        m1_awready;
      logic        m1_wready;
      logic [3:0]  m1_bid;
      logic [1:0]  m1_bresp;
      logic        m1_bvalid;
      logic [3:0]  s_awid;
      logic [31:0] s_awaddr;
      logic [7:0]  s_awlen;
      logic [2:0]  s_awsize;
      logic [1:0]  s_awburst;
      logic        s_awvalid;
      logic [31:0] s_wdata;
      logic [3:0]  s_wstrb;
      logic        s_wlast;
      logic        s_wvalid;
      logic        s_bready;
   } out_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        awv[2];
   logic [3:0]  awid[2];
   logic [31:0] awaddr[2];
   logic [7:0]  awlen[2];
   logic [2:0]  awsize[2];
   logic [1:0]  awburst[2];
   logic        wv[2];
   logic [31:0] wdata[2];
   logic [3:0]  wstrb[2];
   logic        wlast[2];
   logic        bready[2];
   logic        s_awready, s_wready, s_bvalid;
   logic [3:0]  s_bid;
   logic [1:0]  s_bresp;
   out_t        dout[2];

   int tests = 0;
   int fails = 0;

   // transaction model per variant: phase 0 idle / 1 transfer / 2 response
   int ph[2]  = '{0, 0};
   int own[2] = '{0, 0};
   int rr[2]  = '{0, 0};
   bit awok[2] = '{0, 0};
   bit wok[2]  = '{0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      out_t o;
      axi_wr_arbiter #(.FIXED_PRIO(g[0])) u_dut (
         .clk_i(clk), .rst_i(rst),
         .m0_awid_i(awid[0]), .m0_awaddr_i(awaddr[0]), .m0_awlen_i(awlen[0]),
         .m0_awsize_i(awsize[0]), .m0_awburst_i(awburst[0]), .m0_awvalid_i(awv[0]),
         .m0_awready_o(o.m0_awready), .m0_wdata_i(wdata[0]), .m0_wstrb_i(wstrb[0]),
         .m0_wlast_i(wlast[0]), .m0_wvalid_i(wv[0]), .m0_wready_o(o.m0_wready),
         .m0_bid_o(o.m0_bid), .m0_bresp_o(o.m0_bresp), .m0_bvalid_o(o.m0_bvalid),
         .m0_bready_i(bready[0]),
         .m1_awid_i(awid[1]), .m1_awaddr_i(awaddr[1]), .m1_awlen_i(awlen[1]),
         .m1_awsize_i(awsize[1]), .m1_awburst_i(awburst[1]), .m1_awvalid_i(awv[1]),
         .m1_awready_o(o.m1_awready), .m1_wdata_i(wdata[1]), .m1_wstrb_i(wstrb[1]),
         .m1_wlast_i(wlast[1]), .m1_wvalid_i(wv[1]), .m1_wready_o(o.m1_wready),
         .m1_bid_o(o.m1_bid), .m1_bresp_o(o.m1_bresp), .m1_bvalid_o(o.m1_bvalid),
         .m1_bready_i(bready[1]),
         .s_awid_o(o.s_awid), .s_awaddr_o(o.s_awaddr), .s_awlen_o(o.s_awlen),
         .s_awsize_o(o.s_awsize), .s_awburst_o(o.s_awburst), .s_awvalid_o(o.s_awvalid),
         .s_awready_i(s_awready), .s_wdata_o(o.s_wdata), .s_wstrb_o(o.s_wstrb),
         .s_wlast_o(o.s_wlast), .s_wvalid_o(o.s_wvalid), .s_wready_i(s_wready),
         .s_bid_i(s_bid), .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(o.s_bready)
      );
      assign dout[g] = o;
   end

   function automatic out_t model_out(int d);
      out_t e;
      int   m;
      e = '0;
      if (rst || ph[d] == 0)
         return e;
      m = own[d];
      if (ph[d] == 1) begin
         e.s_awid    = awid[m];
         e.s_awaddr  = awaddr[m];
         e.s_awlen   = awlen[m];
         e.s_awsize  = awsize[m];
         e.s_awburst = awburst[m];
         e.s_awvalid = awv[m] && !awok[d];
         e.s_wdata   = wdata[m];
         e.s_wstrb   = wstrb[m];
         e.s_wlast   = wlast[m];
         e.s_wvalid  = wv[m] && !wok[d];
         if (m == 0) begin
            e.m0_awready = s_awready && !awok[d];
            e.m0_wready  = s_wready && !wok[d];
         end else begin
            e.m1_awready = s_awready && !awok[d];
            e.m1_wready  = s_wready && !wok[d];
         end
      end else begin
         if (m == 0) begin
            e.m0_bvalid = s_bvalid; e.m0_bid = s_bid; e.m0_bresp = s_bresp;
         end else begin
            e.m1_bvalid = s_bvalid; e.m1_bid = s_bid; e.m1_bresp = s_bresp;
         end
         e.s_bready = bready[m];
      end
      return e;
   endfunction

   task automatic model_step(int d);
      bit a, w;
      int m;
      m = own[d];
      if (rst) begin
         ph[d] = 0; own[d] = 0; rr[d] = 0; awok[d] = 0; wok[d] = 0;
      end else if (ph[d] == 0) begin
         if (awv[0] || awv[1]) begin
            if (awv[0] && awv[1]) own[d] = (d == 1) ? 0 : rr[d];
            else                  own[d] = awv[0] ? 0 : 1;
            ph[d] = 1; awok[d] = 0; wok[d] = 0;
         end
      end else if (ph[d] == 1) begin
         a = awok[d] || (awv[m] && s_awready);
         w = wok[d] || (wv[m] && s_wready && wlast[m]);
         awok[d] = a; wok[d] = w;
         if (a && w) ph[d] = 2;
      end else begin
         if (s_bvalid && bready[m]) begin
            ph[d] = 0; rr[d] = 1 - m;
         end
      end
   endtask

   // Compare every output of both variants at the falling edge, then advance the model.
   task automatic cycle();
      out_t e;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         e = model_out(d);
         tests++;
         if (dout[d] !== e) begin
            fails++;
            $display("FAIL cyc_outputs dut%0d t=%0t act=%h exp=%h", d, $time, dout[d], e);
         end
      end
      for (int d = 0; d < 2; d++) model_step(d);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         awv[i] = 0; awid[i] = 4'(i + 1); awaddr[i] = (i == 0) ? 32'h1000 : 32'h2000;
         awlen[i] = 0; awsize[i] = 3'd2; awburst[i] = 2'd1;
         wv[i] = 0; wdata[i] = 0; wstrb[i] = 4'hf; wlast[i] = 1; bready[i] = 0;
      end
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = 0; s_bresp = 0;
   endtask

   // One full transaction with the requesters in mask; returns the granted address per variant.
   task automatic contend(input logic [1:0] mask, output logic [31:0] a0, output logic [31:0] a1);
      clear_inputs();
      awv[0] = mask[0]; awv[1] = mask[1]; wv[0] = mask[0]; wv[1] = mask[1];
      s_awready = 1; s_wready = 1;
      cycle();
      a0 = dout[0].s_awaddr;
      a1 = dout[1].s_awaddr;
      cycle();
      s_bvalid = 1; bready[0] = 1; bready[1] = 1;
      cycle();
      clear_inputs();
   endtask

   initial begin
      logic [31:0] a0, a1;
      clear_inputs();
      rst = 1;
      cycle();
      cycle();
      chk("rst_s_awvalid", {31'd0, dout[0].s_awvalid}, 32'd0);
      rst = 0;
      cycle();

      // single write from m0
      awv[0] = 1; awaddr[0] = 32'hA00003F8; wv[0] = 1; wdata[0] = 32'h41; wlast[0] = 1;
      s_awready = 1; s_wready = 1;
      #1 chk("grant_cycle_awvalid", {31'd0, dout[0].s_awvalid}, 32'd0);
      cycle();
      chk("busy_awvalid", {31'd0, dout[0].s_awvalid}, 32'd1);
      chk("busy_awaddr", dout[0].s_awaddr, 32'hA00003F8);
      chk("busy_wdata", dout[0].s_wdata, 32'h41);
      chk("busy_m1_awready", {31'd0, dout[0].m1_awready}, 32'd0);
      cycle();
      awv[0] = 0; wv[0] = 0; s_bvalid = 1; s_bid = 4'd1; bready[0] = 1;
      #1 chk("resp_m0_bvalid", {31'd0, dout[0].m0_bvalid}, 32'd1);
      chk("resp_m0_bid", {28'd0, dout[0].m0_bid}, 32'd1);
      chk("resp_m1_bvalid", {31'd0, dout[0].m1_bvalid}, 32'd0);
      cycle();
      s_bvalid = 0;
      #1 chk("idle_m0_bvalid", {31'd0, dout[0].m0_bvalid}, 32'd0);
      cycle();

      // contention sequence from a fresh reset
      rst = 1; cycle(); rst = 0; cycle();
      contend(2'b11, a0, a1); chk("rr1_dut0", a0, 32'h1000); chk("fx1_dut1", a1, 32'h1000);
      contend(2'b11, a0, a1); chk("rr2_dut0", a0, 32'h2000); chk("fx2_dut1", a1, 32'h1000);
      contend(2'b10, a0, a1); chk("solo_m1_dut0", a0, 32'h2000); chk("solo_m1_dut1", a1, 32'h2000);
      contend(2'b11, a0, a1); chk("rr3_dut0", a0, 32'h1000);

      // m1 wins (round-robin), then B backpressure, then reset while in response
      awv[0] = 1; awv[1] = 1; wv[0] = 1; wv[1] = 1; s_awready = 1; s_wready = 1;
      cycle();
      chk("rr4_dut0", dout[0].s_awaddr, 32'h2000);
      cycle();
      s_bvalid = 1; bready[1] = 0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("bp_m1_bvalid", {31'd0, dout[0].m1_bvalid}, 32'd1);
         chk("bp_s_bready", {31'd0, dout[0].s_bready}, 32'd0);
         cycle();
      end
      bready[1] = 1; rst = 1;
      #1 chk("rst_resp_m1_bvalid", {31'd0, dout[0].m1_bvalid}, 32'd0);
      chk("rst_resp_s_bready", {31'd0, dout[0].s_bready}, 32'd0);
      cycle();
      rst = 0;
      contend(2'b11, a0, a1); chk("post_rst_dut0", a0, 32'h1000);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < 2; i++) begin
            awv[i] = ($urandom_range(0, 2) != 0);
            awid[i] = 4'($urandom); awaddr[i] = $urandom; awlen[i] = 8'($urandom);
            awsize[i] = 3'($urandom); awburst[i] = 2'($urandom);
            wv[i] = $urandom_range(0, 1) != 0; wdata[i] = $urandom; wstrb[i] = 4'($urandom);
            wlast[i] = ($urandom_range(0, 2) == 0); bready[i] = $urandom_range(0, 1) != 0;
         end
         s_awready = $urandom_range(0, 1) != 0; s_wready = $urandom_range(0, 1) != 0;
         s_bvalid = $urandom_range(0, 1) != 0; s_bid = 4'($urandom); s_bresp = 2'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 selects m0 always wins.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports m{0,1}_awid_i/awaddr_i/awlen_i/awsize_i/awburst_i, input, 4/32/8/3/2 bits: AW payload per master.
REQ-005 The block SHALL have ports m{0,1}_awvalid_i, input, and m{0,1}_awready_o, output, 1 bit each: AW handshake per master.
REQ-006 The block SHALL have ports m{0,1}_wdata_i/wstrb_i/wlast_i, input, 32/4/1 bits: W payload per master.
REQ-007 The block SHALL have ports m{0,1}_wvalid_i, input, and m{0,1}_wready_o, output, 1 bit each: W handshake per master.
REQ-008 The block SHALL have ports m{0,1}_bid_o/bresp_o/bvalid_o, output, 4/2/1 bits, and m{0,1}_bready_i, input, 1 bit: B channel per master.
REQ-009 The block SHALL have ports s_aw*_o and s_w*_o, output, same widths as REQ-004/006 plus valid: AW/W toward the shared slave (UART).
REQ-010 The block SHALL have ports s_awready_i and s_wready_i, input, 1 bit each: slave AW/W ready.
REQ-011 The block SHALL have ports s_bid_i/bresp_i/bvalid_i, input, 4/2/1 bits, and s_bready_o, output, 1 bit: slave B channel.

Function
REQ-012 The block SHALL implement states IDLE, BUSY and RESP, with registered grant gnt (0 = m0, 1 = m1) and registered flags aw_done, w_done.
REQ-013 In IDLE, a master SHALL be requesting when its awvalid_i=1; with no request the block SHALL stay in IDLE.
REQ-014 In IDLE with one requester, that master SHALL be granted and the block SHALL enter BUSY on the next edge, clearing aw_done and w_done.
REQ-015 In IDLE with both requesting and FIXED_PRIO=1, m0 SHALL be granted.
REQ-016 In IDLE with both requesting and FIXED_PRIO=0, the master indicated by register prio SHALL be granted; prio SHALL be set to the non-granted master on each return to IDLE.
REQ-017 Arbitration latency SHALL be exactly 1 cycle: no slave valid is driven in the grant cycle, and all outputs toward masters and slave SHALL be 0 in IDLE.
REQ-018 In BUSY, s_aw*_o SHALL be driven from the granted master's AW payload, and s_awvalid_o SHALL equal granted awvalid & !aw_done.
REQ-019 In BUSY, the granted master's awready_o SHALL equal s_awready_i & !aw_done.
REQ-020 In BUSY, s_w*_o SHALL be driven from the granted master's W payload, and s_wvalid_o SHALL equal granted wvalid & !w_done.
REQ-021 In BUSY, the granted master's wready_o SHALL equal s_wready_i & !w_done.
REQ-022 aw_done SHALL set on an AW handshake, and w_done SHALL set on a W handshake with wlast=1; AW and W handshakes in the same cycle SHALL be legal and set both flags.
REQ-023 BUSY SHALL go to RESP in the cycle after both flags are set, or when both handshakes complete in one cycle.
REQ-024 In RESP, s_b*_i SHALL be routed to the granted master, and s_bready_o SHALL equal the granted master's bready_i.
REQ-025 In RESP, the B handshake (s_bvalid_i & bready) SHALL return the block to IDLE on the next edge.
REQ-026 The non-granted master SHALL see awready_o=0, wready_o=0 and bvalid_o=0 at all times, and its payload SHALL never reach the slave.
REQ-027 The grant SHALL be held for the whole transaction; a new request from the other master SHALL NOT preempt it.
REQ-028 An s_bvalid_i outside RESP SHALL be ignored, with s_bready_o=0 and no state change.
REQ-029 Burst length SHALL be honoured only via wlast; beats before wlast SHALL pass through without a state change.

Reset
REQ-030 With rst_i=1 at an edge, the state SHALL become IDLE, and gnt, prio, aw_done and w_done SHALL become 0.
REQ-031 During reset, all ready and valid outputs SHALL be 0 in the same cycle as rst_i is sampled high.
REQ-032 A reset asserted mid-transaction (BUSY or RESP) SHALL abandon the transaction without issuing B to any master.
REQ-033 After reset deassertion, the first simultaneous request with FIXED_PRIO=0 SHALL grant m0.

Verification
REQ-034 Single write: m0 AW+W asserted with awaddr=0xA00003F8, wdata=0x41, wlast=1, and the slave ready -> grant at cycle 1, slave valids at cycle 1, m0_bvalid_o when s_bvalid_i, IDLE after bready.
REQ-035 Contention, round-robin: m0 and m1 request together twice -> order m0, m1, then m0, m1; the m1 payload never appears while m0 holds the grant.
REQ-036 Contention with FIXED_PRIO=1: both requesting continuously -> m0 granted every arbitration, and m1 is granted only when m0_awvalid_i=0 in IDLE.
REQ-037 Split handshakes: s_awready_i at cycle 2, s_wready_i at cycle 5, 3-beat burst -> aw_done at 2, three W beats pass, RESP after the wlast beat, and no duplicate AW.
REQ-038 Backpressure on B: s_bvalid_i=1 and m1_bready_i=0 for 4 cycles -> stays in RESP, s_bready_o=0, then IDLE one cycle after bready=1.
REQ-039 Reset in RESP: rst_i pulsed while s_bvalid_i=1 -> all outputs 0 in that cycle, IDLE, no bvalid to either master, and the next contention grants m0.
